// File: rtl/mmio_timer_pkg.sv
// Shared memory-bus definitions: command codes, peripheral addresses and the
// timer register map used by mmio_timer and its prescaler.
package mmio_timer_pkg;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam logic [8:0] LEDADDR = 9'h1FE;
    localparam logic [8:0] SWADDR  = 9'h1FF;

    localparam logic [1:0] OFF_CTRL  = 2'd0;
    localparam logic [1:0] OFF_LOAD  = 2'd1;
    localparam logic [1:0] OFF_COUNT = 2'd2;
    localparam logic [1:0] OFF_STAT  = 2'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } timer_state_e;

    // A 4-word register window is selected by the upper seven address bits
    function automatic logic window_hit(input logic [8:0] addr, input logic [8:0] base);
        return (addr[8:2] == base[8:2]);
    endfunction

endpackage

// File: rtl/mmio_timer_presc.sv
// Prescaler for mmio_timer: counts 0..PRESCALE-1 while running and emits a
// one-cycle tick on the last phase; restart forces the phase back to zero.
module mmio_timer_presc
    import mmio_timer_pkg::*;
#(
    parameter logic [15:0] PRESCALE = 16'd1000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic restart,
    output logic tick
);

    logic [15:0] presc_r;
    logic        wrap_s;

    assign wrap_s = (presc_r == (PRESCALE - 16'd1));
    assign tick   = run & wrap_s;

    // Phase counter: held at zero while idle or restarted, wraps after the last phase
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_r <= 16'd0;
        end else if (restart || !run || wrap_s) begin
            presc_r <= 16'd0;
        end else begin
            presc_r <= presc_r + 16'd1;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer with prescaler, auto-reload and sticky expiry.
// Optional interrupt output enabled by defining MMIO_TIMER_IRQ_EN.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [15:0] PRESCALE = 16'd1000,
    parameter logic [8:0]  BASEADDR = 9'h180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data
`ifdef MMIO_TIMER_IRQ_EN
    ,
    output logic        irq
`endif
);

    timer_state_e state_r;
    logic         en_r;
    logic         auto_r;
    logic         ie_s;
    logic [15:0]  load_r;
    logic [15:0]  count_r;
    logic         exp_r;

    logic         hit_s;
    logic         rd_s;
    logic         wr_s;
    logic         wr_ctrl_s;
    logic         wr_load_s;
    logic         wr_stat_s;
    logic         tick_s;
    logic         expire_s;
    logic [15:0]  rdata_s;

    assign hit_s     = window_hit(mem_addr, BASEADDR);
    assign rd_s      = hit_s && (mem_cmd == MREAD);
    assign wr_s      = hit_s && (mem_cmd == MWRITE);
    assign wr_ctrl_s = wr_s && (mem_addr[1:0] == OFF_CTRL);
    assign wr_load_s = wr_s && (mem_addr[1:0] == OFF_LOAD);
    assign wr_stat_s = wr_s && (mem_addr[1:0] == OFF_STAT);
    assign expire_s  = tick_s && (count_r == 16'd0);

    mmio_timer_presc #(
        .PRESCALE (PRESCALE)
    ) u_presc (
        .clk     (clk),
        .reset   (reset),
        .run     (state_r == ST_RUN),
        .restart (wr_ctrl_s),
        .tick    (tick_s)
    );

    // Run/idle FSM; a CTRL write overrides the one-shot shutdown on the same edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            en_r    <= 1'b0;
        end else if (wr_ctrl_s) begin
            en_r    <= write_data[CTRL_EN];
            state_r <= write_data[CTRL_EN] ? ST_RUN : ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    en_r    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                ST_RUN: begin
                    if (expire_s && !auto_r) begin
                        en_r    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        en_r    <= 1'b1;
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    en_r    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Register file: a LOAD write beats the tick on COUNT, expiry beats a STAT clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            auto_r  <= 1'b0;
            load_r  <= 16'd0;
            count_r <= 16'd0;
            exp_r   <= 1'b0;
        end else begin
            if (wr_ctrl_s) begin
                auto_r <= write_data[CTRL_AUTO];
            end else begin
                auto_r <= auto_r;
            end

            if (wr_load_s) begin
                load_r  <= write_data;
                count_r <= write_data;
            end else if (tick_s && (count_r != 16'd0)) begin
                load_r  <= load_r;
                count_r <= count_r - 16'd1;
            end else if (expire_s && auto_r) begin
                load_r  <= load_r;
                count_r <= load_r;
            end else begin
                load_r  <= load_r;
                count_r <= count_r;
            end

            if (expire_s) begin
                exp_r <= 1'b1;
            end else if (wr_stat_s) begin
                exp_r <= 1'b0;
            end else begin
                exp_r <= exp_r;
            end
        end
    end

`ifdef MMIO_TIMER_IRQ_EN
    logic ie_r;
    logic irq_r;

    assign ie_s = ie_r;
    assign irq  = irq_r;

    // Interrupt enable and the registered interrupt line
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ie_r  <= 1'b0;
            irq_r <= 1'b0;
        end else begin
            if (wr_ctrl_s) begin
                ie_r <= write_data[CTRL_IE];
            end else begin
                ie_r <= ie_r;
            end
            irq_r <= exp_r & ie_r;
        end
    end
`else
    assign ie_s = 1'b0;
`endif

    // Read mux for the four-word window
    always_comb begin
        rdata_s = 16'd0;
        case (mem_addr[1:0])
            OFF_CTRL:  rdata_s = {13'd0, ie_s, auto_r, en_r};
            OFF_LOAD:  rdata_s = load_r;
            OFF_COUNT: rdata_s = count_r;
            OFF_STAT:  rdata_s = {15'd0, exp_r};
            default:   rdata_s = 16'd0;
        endcase
    end

    // Shared bus: drive only for our own reads, and never while in reset
    assign read_data = (reset && rd_s) ? rdata_s : 16'bz;

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer (PRESCALE=4): transaction-level model plus
// directed hand-computed checks. Define MMIO_TIMER_IRQ_EN to cover the irq output.
`timescale 1ns/1ps
module tb_mmio_timer;
    import mmio_timer_pkg::*;

    localparam logic [15:0] P    = 16'd4;
    localparam logic [8:0]  BASE = 9'h180;
    localparam logic [8:0]  A_CTRL  = 9'h180;
    localparam logic [8:0]  A_LOAD  = 9'h181;
    localparam logic [8:0]  A_COUNT = 9'h182;
    localparam logic [8:0]  A_STAT  = 9'h183;
`ifdef MMIO_TIMER_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic [1:0]  mem_cmd    = MREAD;
    logic [8:0]  mem_addr   = 9'h182;
    logic [15:0] write_data = 16'd0;
    wire  [15:0] read_data;
`ifdef MMIO_TIMER_IRQ_EN
    logic        irq;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    mmio_timer #(.PRESCALE(P), .BASEADDR(BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data)
`ifdef MMIO_TIMER_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: cycles since the timer was (re)started drive the ticks
    typedef struct {
        bit          en;
        bit          autorl;
        bit          ie;
        logic [15:0] load;
        logic [15:0] cnt;
        bit          expf;
        bit          irq;
        int          age;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.en = 0; r.autorl = 0; r.ie = 0; r.load = 16'd0; r.cnt = 16'd0;
        r.expf = 0; r.irq = 0; r.age = 0;
        return r;
    endfunction

    function automatic bit in_window(input logic [8:0] a);
        return (a >= BASE) && (a < BASE + 9'd4);
    endfunction

    function automatic model_t model_step(input model_t s, input logic [1:0] c,
                                          input logic [8:0] a, input logic [15:0] d);
        model_t      n;
        logic [8:0]  off;
        bit          tick;
        bit          expire;
        n      = s;
        off    = a - BASE;
        tick   = s.en && ((s.age % int'(P)) == int'(P) - 1);
        expire = tick && (s.cnt == 16'd0);
        if (tick) begin
            if (s.cnt != 16'd0) n.cnt = s.cnt - 16'd1;
            else begin
                n.expf = 1;
                if (s.autorl) n.cnt = s.load;
                else n.en = 0;
            end
        end
        n.age = s.age + 1;
        n.irq = s.expf & s.ie;
        if (in_window(a) && c == MWRITE) begin
            case (off[1:0])
                2'd0: begin
                    n.en = d[0]; n.autorl = d[1];
                    if (IRQ) n.ie = d[2];
                    n.age = 0;
                end
                2'd1: begin n.load = d; n.cnt = d; end
                2'd2: ;
                default: if (!expire) n.expf = 0;
            endcase
        end
        if (!n.en) n.age = 0;
        return n;
    endfunction

    function automatic logic [15:0] model_read(input model_t s, input logic [8:0] a);
        logic [8:0] off;
        off = a - BASE;
        case (off[1:0])
            2'd0:    return {13'd0, s.ie, s.autorl, s.en};
            2'd1:    return s.load;
            2'd2:    return s.cnt;
            default: return {15'd0, s.expf};
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= model_reset();
        else        m <= model_step(m, mem_cmd, mem_addr, write_data);
    end

    // Compare process: every cycle, read_data and irq against the model
    always @(negedge clk) begin
        n_chk++;
        if (reset && mem_cmd == MREAD && in_window(mem_addr)) begin
            if (read_data !== model_read(m, mem_addr)) begin
                n_fail++;
                $display("FAIL model_read @%0t addr=%h: got %h expected %h",
                         $time, mem_addr, read_data, model_read(m, mem_addr));
            end
        end else begin
            if (read_data !== 16'bz) begin
                n_fail++;
                $display("FAIL bus_release @%0t addr=%h cmd=%b: got %h expected z",
                         $time, mem_addr, mem_cmd, read_data);
            end
        end
`ifdef MMIO_TIMER_IRQ_EN
        n_chk++;
        if (irq !== m.irq) begin
            n_fail++;
            $display("FAIL model_irq @%0t: got %b expected %b", $time, irq, m.irq);
        end
`endif
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    task automatic bus(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        mem_cmd = c; mem_addr = a; write_data = d;
        @(posedge clk); #2;
        mem_cmd = MNONE;
    endtask

    task automatic wr(input logic [8:0] a, input logic [15:0] d);
        bus(MWRITE, a, d);
    endtask

    task automatic idle(input int n);
        mem_cmd = MNONE;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic rd(input logic [8:0] a, input logic [15:0] expv, input string name);
        mem_cmd = MREAD; mem_addr = a;
        #1;
        chk(name, read_data, expv);
        @(posedge clk); #1;
        mem_cmd = MNONE;
    endtask

`ifdef MMIO_TIMER_IRQ_EN
    task automatic irq_chk(input logic expv, input string name);
        mem_cmd = MNONE;
        #1;
        chk(name, {15'd0, irq}, {15'd0, expv});
        @(posedge clk); #2;
    endtask
`endif

    initial begin
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        mem_cmd = MNONE;

        rd(A_CTRL,  16'd0, "rst_ctrl");
        rd(A_LOAD,  16'd0, "rst_load");
        rd(A_COUNT, 16'd0, "rst_count");
        rd(A_STAT,  16'd0, "rst_stat");

        // One-shot countdown from 3
        wr(A_LOAD, 16'd3);
        wr(A_CTRL, 16'd1);
        for (int k = 0; k < 16; k++)
            rd(A_COUNT, 16'(3 - k / 4), "oneshot_count");
        rd(A_STAT, 16'd1, "oneshot_exp");
        rd(A_CTRL, 16'd0, "oneshot_en_off");

        // Auto-reload with LOAD=2: expiry every 12 cycles
        wr(A_STAT, 16'd0);
        wr(A_LOAD, 16'd2);
        wr(A_CTRL, 16'd3);
        for (int k = 0; k < 12; k++)
            rd(A_COUNT, 16'(2 - k / 4), "auto_count");
        rd(A_STAT, 16'd1, "auto_exp1");
        rd(A_COUNT, 16'd2, "auto_reload");
        wr(A_STAT, 16'd0);
        idle(8);
        rd(A_STAT, 16'd0, "auto_exp_clear");
        rd(A_STAT, 16'd1, "auto_exp2");
        rd(A_CTRL, 16'd3, "auto_still_run");
        wr(A_CTRL, 16'd0);

        // Address decode, bus release and read-only COUNT
        wr(A_LOAD, 16'h1234);
        wr(A_STAT, 16'd0);
        wr(A_CTRL, 16'd2);
        rd(9'h182, 16'h1234, "decode_count");
        bus(MREAD, 9'h100, 16'd0);
        bus(MREAD, 9'h0A0, 16'd0);
        bus(MREAD, 9'h102, 16'd0);
        bus(MNONE, 9'h182, 16'd0);
        wr(A_COUNT, 16'h5555);
        rd(A_COUNT, 16'h1234, "count_readonly");
        wr(A_CTRL, 16'd4);
        rd(A_CTRL, IRQ ? 16'd4 : 16'd0, "ctrl_ie_bit");
        wr(A_CTRL, 16'd0);

        // STAT clear on the expiry edge: expiry wins
        wr(A_LOAD, 16'd1);
        wr(A_CTRL, 16'd1);
        idle(7);
        wr(A_STAT, 16'd0);
        rd(A_STAT, 16'd1, "stat_vs_expiry");
        rd(A_CTRL, 16'd0, "oneshot2_en_off");

        // LOAD write on a tick edge, then EN=1 rewrite restarting the prescaler
        wr(A_LOAD, 16'd5);
        wr(A_CTRL, 16'd1);
        idle(7);
        wr(A_LOAD, 16'd7);
        rd(A_COUNT, 16'd7, "load_vs_tick");
        idle(2);
        rd(A_COUNT, 16'd7, "presc_kept_a");
        rd(A_COUNT, 16'd6, "presc_kept_b");
        wr(A_CTRL, 16'd1);
        idle(2);
        rd(A_COUNT, 16'd6, "restart_a");
        rd(A_COUNT, 16'd6, "restart_b");
        rd(A_COUNT, 16'd5, "restart_c");

        // Asynchronous reset mid-count
        mem_cmd = MREAD; mem_addr = A_COUNT;
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        mem_cmd = MNONE;
        rd(A_COUNT, 16'd0, "midrst_count");
        rd(A_CTRL,  16'd0, "midrst_ctrl");
        rd(A_LOAD,  16'd0, "midrst_load");
        rd(A_STAT,  16'd0, "midrst_stat");
        idle(10);
        rd(A_STAT,  16'd0, "midrst_no_tick");
        rd(A_COUNT, 16'd0, "midrst_count_hold");

`ifdef MMIO_TIMER_IRQ_EN
        wr(A_LOAD, 16'd1);
        wr(A_CTRL, 16'd5);
        idle(8);
        irq_chk(1'b0, "irq_lag");
        irq_chk(1'b1, "irq_rise");
        wr(A_STAT, 16'd0);
        irq_chk(1'b1, "irq_hold");
        irq_chk(1'b0, "irq_fall");
`endif

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
